id_hazard_unit: RTL and testbench

// - ID-stage interlock/forwarding controller: the return path of the ID->EX pipeline interface.
// - Keeps shadow copies of EX- and MEM-stage write info (wreg, m2reg, wn) in lockstep with the pipeline registers.
// - Drives operand-forward selects, load-use stall, ID/EX bubble insert and taken-branch flush back to ID/IF.

---
 rtl/cpu_pipe_pkg.sv | 14 +
 rtl/hazard_fwd_cmp.sv | 35 +++
 rtl/id_hazard_unit.sv | 144 ++++++++++++++
 tb/tb_id_hazard_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: forward-select encoding and hazard FSM states.
package cpu_pipe_pkg;

  localparam logic [1:0] FWD_RF     = 2'd0;
  localparam logic [1:0] FWD_EXALU  = 2'd1;
  localparam logic [1:0] FWD_MEMALU = 2'd2;
  localparam logic [1:0] FWD_MEMLD  = 2'd3;

  typedef enum logic {
    RUN    = 1'b0,
    LSTALL = 1'b1
  } haz_state_t;

endpackage

// File: rtl/hazard_fwd_cmp.sv
// One-operand forward compare: picks the youngest in-flight producer of src.
module hazard_fwd_cmp
  import cpu_pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              use_src,
  input  logic              ex_wreg,
  input  logic              ex_m2reg,
  input  logic [REG_AW-1:0] ex_wn,
  input  logic              mem_wreg,
  input  logic              mem_m2reg,
  input  logic [REG_AW-1:0] mem_wn,
  output logic [1:0]        fwd
);

  logic ex_hit;
  logic mem_hit;

  // $0 is never a real destination, so a zero wn can not match.
  assign ex_hit  = use_src & ex_wreg  & (ex_wn  != '0) & (ex_wn  == src);
  assign mem_hit = use_src & mem_wreg & (mem_wn != '0) & (mem_wn == src);

  // A load still in EX shadows any older MEM producer; the load-use stall covers it.
  always_comb begin
    fwd = FWD_RF;
    if (ex_hit) begin
      fwd = ex_m2reg ? FWD_RF : FWD_EXALU;
    end else if (mem_hit) begin
      fwd = mem_m2reg ? FWD_MEMLD : FWD_MEMALU;
    end
  end

endmodule

// File: rtl/id_hazard_unit.sv
// ID-stage interlock/forwarding controller. Define HAZ_STATS_EN to add
// stall_cnt/flush_cnt statistics outputs.
module id_hazard_unit
  import cpu_pipe_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int LOAD_STALL_N = 1
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wreg,
  input  logic              id_m2reg,
  input  logic [REG_AW-1:0] id_wn,
  input  logic              id_br_taken,
  output logic [1:0]        fwda,
  output logic [1:0]        fwdb,
  output logic              stall,
  output logic              bubble,
  output logic              flush
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_N - 1);

  logic              ex_wreg_reg,  ex_m2reg_reg;
  logic [REG_AW-1:0] ex_wn_reg;
  logic              mem_wreg_reg, mem_m2reg_reg;
  logic [REG_AW-1:0] mem_wn_reg;

  haz_state_t state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;
  logic       hazard;

  logic [1:0][REG_AW-1:0] src;
  logic [1:0]             use_src;
  logic [1:0][1:0]        fwd;

  assign src     = {id_rt, id_rs};
  assign use_src = {id_use_rt, id_use_rs};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cmp
      hazard_fwd_cmp #(.REG_AW(REG_AW)) u_cmp (
        .src       (src[gi]),
        .use_src   (use_src[gi]),
        .ex_wreg   (ex_wreg_reg),
        .ex_m2reg  (ex_m2reg_reg),
        .ex_wn     (ex_wn_reg),
        .mem_wreg  (mem_wreg_reg),
        .mem_m2reg (mem_m2reg_reg),
        .mem_wn    (mem_wn_reg),
        .fwd       (fwd[gi])
      );
    end
  endgenerate

  assign fwda = fwd[0];
  assign fwdb = fwd[1];

  assign hazard = ex_wreg_reg & ex_m2reg_reg & (ex_wn_reg != '0) &
                  ((id_use_rs & (id_rs == ex_wn_reg)) |
                   (id_use_rt & (id_rt == ex_wn_reg)));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      RUN: begin
        if (hazard && (LOAD_STALL_N > 1)) begin
          state_next = LSTALL;
          cnt_next   = STALL_RELOAD;
        end
      end
      LSTALL: begin
        cnt_next = cnt_reg - 3'd1;
        if (cnt_reg == 3'd1) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    case (state_reg)
      RUN:     stall = hazard;
      LSTALL:  stall = 1'b1;
      default: stall = 1'b0;
    endcase
    bubble = stall;
    flush  = id_br_taken & ~stall;
  end

  // Downstream stages wait on the multi-cycle memory during LSTALL, so the shadows hold.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ex_wreg_reg   <= 1'b0;
      ex_m2reg_reg  <= 1'b0;
      ex_wn_reg     <= '0;
      mem_wreg_reg  <= 1'b0;
      mem_m2reg_reg <= 1'b0;
      mem_wn_reg    <= '0;
    end else if (state_reg == RUN) begin
      mem_wreg_reg  <= ex_wreg_reg;
      mem_m2reg_reg <= ex_m2reg_reg;
      mem_wn_reg    <= ex_wn_reg;
      ex_wreg_reg   <= bubble ? 1'b0 : id_wreg;
      ex_m2reg_reg  <= bubble ? 1'b0 : id_m2reg;
      ex_wn_reg     <= bubble ? '0   : id_wn;
    end
  end

`ifdef HAZ_STATS_EN
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_hazard_unit.sv
// Directed bench: one LOAD_STALL_N=1 and one LOAD_STALL_N=3 unit share the same ID stream.
module tb_id_hazard_unit;

  logic       clk = 1'b0;
  logic       clrn;
  logic [4:0] id_rs, id_rt, id_wn;
  logic       id_use_rs, id_use_rt, id_wreg, id_m2reg, id_br_taken;

  logic [1:0] fwda1, fwdb1, fwda3, fwdb3;
  logic       stall1, bubble1, flush1, stall3, bubble3, flush3;
`ifdef HAZ_STATS_EN
  logic [31:0] stall_cnt1, flush_cnt1, stall_cnt3, flush_cnt3;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  id_hazard_unit #(.REG_AW(5), .LOAD_STALL_N(1)) dut1 (
    .clk(clk), .clrn(clrn), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg),
    .id_m2reg(id_m2reg), .id_wn(id_wn), .id_br_taken(id_br_taken),
    .fwda(fwda1), .fwdb(fwdb1), .stall(stall1), .bubble(bubble1), .flush(flush1)
`ifdef HAZ_STATS_EN
    , .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
`endif
  );

  id_hazard_unit #(.REG_AW(5), .LOAD_STALL_N(3)) dut3 (
    .clk(clk), .clrn(clrn), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg),
    .id_m2reg(id_m2reg), .id_wn(id_wn), .id_br_taken(id_br_taken),
    .fwda(fwda3), .fwdb(fwdb3), .stall(stall3), .bubble(bubble3), .flush(flush3)
`ifdef HAZ_STATS_EN
    , .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3)
`endif
  );

  logic [6:0] o1, o3;
  assign o1 = {fwda1, fwdb1, stall1, bubble1, flush1};
  assign o3 = {fwda3, fwdb3, stall3, bubble3, flush3};

  // Expected vector: {fwda, fwdb, stall, bubble, flush}
  function automatic logic [6:0] ev(int a, int b, bit s, bit bu, bit fl);
    logic [1:0] fa, fb;
    fa = 2'(a);
    fb = 2'(b);
    return {fa, fb, s, bu, fl};
  endfunction

  task automatic chk(string tag, logic [6:0] obs, logic [6:0] exp);
    vectors++;
    assert (obs === exp) begin
      $display("vec %0d %s obs=%b exp=%b ok", vectors, tag, obs, exp);
    end else begin
      miscompares++;
      $error("FAIL %s observed={fa,fb,st,bu,fl}=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk2(string tag, logic [6:0] e1, logic [6:0] e3);
    #1;
    chk({tag, "/n1"}, o1, e1);
    chk({tag, "/n3"}, o3, e3);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(int rs, int rt, bit urs, bit urt, bit wr, bit m2, int wn, bit br);
    id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = urs; id_use_rt = urt;
    id_wreg = wr; id_m2reg = m2; id_wn = 5'(wn); id_br_taken = br;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    clrn = 1'b0;
    nop();
    #2;
    chk2("reset", ev(0,0,0,0,0), ev(0,0,0,0,0));
    tick();
    clrn = 1'b1;

    // ALU back-to-back: add $3 ; sub $4,$3,$6 ; and $7,$3,$8
    set_id(1, 2, 1, 1, 1, 0, 3, 0);
    chk2("add3", ev(0,0,0,0,0), ev(0,0,0,0,0));
    tick();
    set_id(3, 6, 1, 1, 1, 0, 4, 0);
    chk2("fwd_ex", ev(1,0,0,0,0), ev(1,0,0,0,0));
    tick();
    set_id(3, 8, 1, 1, 1, 0, 7, 0);
    chk2("fwd_mem", ev(2,0,0,0,0), ev(2,0,0,0,0));
    tick();
    nop(); tick(); tick();

    // Load-use: lw $5 ; add $6,$2,$5 held until both units release
    set_id(1, 0, 1, 0, 1, 1, 5, 0);
    chk2("lw5", ev(0,0,0,0,0), ev(0,0,0,0,0));
    tick();
    set_id(2, 5, 1, 1, 1, 0, 6, 0);
    chk2("lu_c0", ev(0,0,1,1,0), ev(0,0,1,1,0));
    tick();
    chk2("lu_c1", ev(0,3,0,0,0), ev(0,3,1,1,0));
    tick();
    chk2("lu_c2", ev(0,0,0,0,0), ev(0,3,1,1,0));
    tick();
    chk2("lu_c3", ev(0,0,0,0,0), ev(0,3,0,0,0));
    tick();
    nop(); tick(); tick();

    // $0 destination: lw $0 then readers of $0 never stall or forward
    set_id(1, 0, 1, 0, 1, 1, 0, 0);
    tick();
    set_id(0, 0, 1, 1, 1, 0, 9, 0);
    chk2("zero_ld", ev(0,0,0,0,0), ev(0,0,0,0,0));
    tick();
    set_id(0, 9, 1, 1, 1, 0, 10, 0);
    chk2("zero_mem", ev(0,1,0,0,0), ev(0,1,0,0,0));
    tick();
    nop(); tick(); tick();

    // Branch during load-use stall: lw $5 ; beq $5,$0 taken
    set_id(1, 0, 1, 0, 1, 1, 5, 0);
    tick();
    set_id(5, 0, 1, 1, 0, 0, 0, 1);
    chk2("br_c0", ev(0,0,1,1,0), ev(0,0,1,1,0));
    tick();
    chk2("br_c1", ev(3,0,0,0,1), ev(3,0,1,1,0));
    tick();
    chk2("br_c2", ev(0,0,0,0,1), ev(3,0,1,1,0));
    tick();
    chk2("br_c3", ev(0,0,0,0,1), ev(3,0,0,0,1));
    tick();
    nop();
    chk2("br_c4", ev(0,0,0,0,0), ev(0,0,0,0,0));
    tick(); tick();

    // Reset in the middle of a long stall
    set_id(1, 0, 1, 0, 1, 1, 5, 0);
    tick();
    set_id(2, 5, 1, 1, 1, 0, 6, 0);
    chk2("rs_c0", ev(0,0,1,1,0), ev(0,0,1,1,0));
    tick();
    chk2("rs_c1", ev(0,3,0,0,0), ev(0,3,1,1,0));
    clrn = 1'b0;
    chk2("rs_async", ev(0,0,0,0,0), ev(0,0,0,0,0));
    tick();
    clrn = 1'b1;
    chk2("rs_after", ev(0,0,0,0,0), ev(0,0,0,0,0));
    nop();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
